// File: rtl/memoria_lector_pkg.sv
// Shared widths, defaults and state encoding for the register-file burst reader.
package memoria_lector_pkg;

  localparam int unsigned N_DEF    = 16;
  localparam int unsigned NREG_DEF = 16;
  localparam int unsigned AW       = 4;
  localparam int unsigned CW       = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  // Burst lengths beyond the register file size read each entry once.
  function automatic logic [CW-1:0] clamp_count(input logic [CW-1:0] c);
    return (c > CW'(NREG_DEF)) ? CW'(NREG_DEF) : c;
  endfunction

endpackage

// File: rtl/memoria_lector_mux.sv
// Combinational 16:1 selection of one register-file entry.
module memoria_lector_mux
  import memoria_lector_pkg::*;
#(
  parameter int unsigned N    = N_DEF,
  parameter int unsigned NREG = NREG_DEF
) (
  input  logic [NREG*N-1:0] regs,
  input  logic [AW-1:0]     sel,
  output logic [N-1:0]      dout
);

  always_comb begin
    dout = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (sel == AW'(i)) dout = regs[i*N +: N];
    end
  end

endmodule

// File: rtl/memoria_lector.sv
// Streams a burst of register-file entries out over a valid/ready interface.
module memoria_lector
  import memoria_lector_pkg::*;
#(
  parameter int unsigned N    = N_DEF,
  parameter int unsigned NREG = NREG_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [AW-1:0]     base_addr,
  input  logic [CW-1:0]     count,
  input  logic [NREG*N-1:0] regs,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [N-1:0]      out_data,
  output logic [AW-1:0]     out_addr,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  state_t        state, state_n;
  logic [AW-1:0] addr, addr_n, addr_inc, mux_sel, oaddr_n;
  logic [CW-1:0] remaining, rem_n, count_clamped;
  logic [N-1:0]  mux_dout, data_n;
  logic          last_n;

  assign addr_inc      = addr + AW'(1);
  assign count_clamped = clamp_count(count);
  // In IDLE the first beat comes from base_addr; in SEND we prefetch the next entry.
  assign mux_sel       = (state == IDLE) ? base_addr : addr_inc;

  memoria_lector_mux #(.N(N), .NREG(NREG)) u_mux (
    .regs (regs),
    .sel  (mux_sel),
    .dout (mux_dout)
  );

  always_comb begin
    state_n = state;
    addr_n  = addr;
    rem_n   = remaining;
    data_n  = out_data;
    oaddr_n = out_addr;
    last_n  = out_last;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (count == '0) begin
            state_n = DONE;
          end else begin
            state_n = SEND;
            addr_n  = base_addr;
            rem_n   = count_clamped;
            data_n  = mux_dout;
            oaddr_n = base_addr;
            last_n  = (count_clamped == CW'(1));
          end
        end
      end
      SEND: begin
        if (out_ready) begin
          if (remaining == CW'(1)) begin
            state_n = DONE;
            rem_n   = '0;
            last_n  = 1'b0;
          end else begin
            addr_n  = addr_inc;
            rem_n   = remaining - CW'(1);
            data_n  = mux_dout;
            oaddr_n = addr_inc;
            last_n  = (remaining == CW'(2));
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      out_data  <= '0;
      out_addr  <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      addr      <= addr_n;
      remaining <= rem_n;
      out_data  <= data_n;
      out_addr  <= oaddr_n;
      out_last  <= last_n;
      out_valid <= (state_n == SEND);
      busy      <= (state_n != IDLE);
      done      <= (state_n == DONE);
    end
  end

endmodule

// File: tb/tb_memoria_lector.sv
// Directed and random bursts checked against a queue-based transaction model.
module tb_memoria_lector;
  import memoria_lector_pkg::*;

  localparam int unsigned W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [3:0]        base_addr;
  logic [4:0]        count;
  logic [16*W-1:0]   regs;
  logic              out_ready;
  logic              out_valid;
  logic [W-1:0]      out_data;
  logic [3:0]        out_addr;
  logic              out_last;
  logic              busy;
  logic              done;

  logic [W-1:0] rf [16];

  always #5 clk = ~clk;

  always_comb begin
    regs = '0;
    for (int i = 0; i < 16; i++) regs[i*W +: W] = rf[i];
  end

  memoria_lector #(.N(W), .NREG(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .count     (count),
    .regs      (regs),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Transaction model: queue of addresses still to be delivered, data captured at load.
  int         m_q[$];
  logic [W-1:0] m_data;
  bit         m_done;

  typedef struct {
    logic [3:0]   a;
    logic [W-1:0] d;
    logic         l;
  } beat_t;
  beat_t log_q[$];

  task automatic model_clear();
    m_q.delete();
    m_done = 1'b0;
    m_data = '0;
  endtask

  task automatic model_step();
    int k;
    if (m_done) begin
      m_done = 1'b0;
    end else if (m_q.size() == 0) begin
      if (start) begin
        if (count == 5'd0) begin
          m_done = 1'b1;
        end else begin
          k = (int'(count) > 16) ? 16 : int'(count);
          for (int i = 0; i < k; i++) m_q.push_back((int'(base_addr) + i) % 16);
          m_data = rf[base_addr];
        end
      end
    end else if (out_ready) begin
      void'(m_q.pop_front());
      if (m_q.size() == 0) m_done = 1'b1;
      else m_data = rf[m_q[0]];
    end
  endtask

  task automatic compare_outputs();
    bit act;
    act = (m_q.size() != 0);
    check("out_valid", 32'(out_valid), 32'(act));
    check("busy", 32'(busy), 32'(act || m_done));
    check("done", 32'(done), 32'(m_done));
    if (act) begin
      check("out_data", 32'(out_data), 32'(m_data));
      check("out_addr", 32'(out_addr), 32'(m_q[0]));
      check("out_last", 32'(out_last), 32'(m_q.size() == 1));
    end
  endtask

  // Called at a negedge with inputs already driven; advances one clock and checks.
  task automatic cycle();
    beat_t b;
    if (out_valid && out_ready) begin
      b.a = out_addr; b.d = out_data; b.l = out_last;
      log_q.push_back(b);
    end
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_data"},  32'(out_data),  32'd0);
    check({tag, "_addr"},  32'(out_addr),  32'd0);
    check({tag, "_last"},  32'(out_last),  32'd0);
    check({tag, "_busy"},  32'(busy),      32'd0);
    check({tag, "_done"},  32'(done),      32'd0);
  endtask

  task automatic check_beat(input int i, input logic [3:0] a, input logic [W-1:0] d, input logic l);
    if (i >= log_q.size()) begin
      check($sformatf("beat%0d_present", i), 32'd0, 32'd1);
    end else begin
      check($sformatf("beat%0d_addr", i), 32'(log_q[i].a), 32'(a));
      check($sformatf("beat%0d_data", i), 32'(log_q[i].d), 32'(d));
      check($sformatf("beat%0d_last", i), 32'(log_q[i].l), 32'(l));
    end
  endtask

  // span = cycles from the start cycle to the done cycle, both inclusive.
  task automatic run_burst(input logic [3:0] b, input logic [4:0] c, output int span);
    int idx;
    log_q.delete();
    base_addr = b; count = c; start = 1'b1; out_ready = 1'b1;
    cycle();
    start = 1'b0;
    idx = 1;
    while (!done && idx < 40) begin
      cycle();
      idx++;
    end
    span = done ? idx + 1 : -1;
    cycle();
  endtask

  task automatic load_defaults();
    rf[0]  = 16'h0003; rf[1]  = 16'h0003; rf[2]  = 16'h0001; rf[3]  = 16'h1234;
    rf[4]  = 16'h0F0F; rf[5]  = 16'h7777; rf[6]  = 16'h0025; rf[7]  = 16'h0000;
    rf[8]  = 16'h5A5A; rf[9]  = 16'h0404; rf[10] = 16'h1357; rf[11] = 16'h2468;
    rf[12] = 16'hC0DE; rf[13] = 16'h00FF; rf[14] = 16'hA204; rf[15] = 16'h8004;
  endtask

  initial begin
    int span;
    load_defaults();
    model_clear();
    rst = 1'b1; start = 1'b0; base_addr = '0; count = '0; out_ready = 1'b1;
    #1;
    check_zero_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) cycle();

    // Basic burst from entry 0.
    run_burst(4'd0, 5'd3, span);
    check("b3_span", 32'(span), 32'd5);
    check("b3_beats", 32'(log_q.size()), 32'd3);
    check_beat(0, 4'd0, 16'h0003, 1'b0);
    check_beat(1, 4'd1, 16'h0003, 1'b0);
    check_beat(2, 4'd2, 16'h0001, 1'b1);

    // Address wrap from 15 to 0.
    run_burst(4'd14, 5'd4, span);
    check("wrap_span", 32'(span), 32'd6);
    check_beat(0, 4'd14, 16'hA204, 1'b0);
    check_beat(1, 4'd15, 16'h8004, 1'b0);
    check_beat(2, 4'd0,  16'h0003, 1'b0);
    check_beat(3, 4'd1,  16'h0003, 1'b1);

    // Backpressure: first beat held for three cycles.
    log_q.delete();
    base_addr = 4'd6; count = 5'd2; start = 1'b1; out_ready = 1'b0;
    cycle();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("stall%0d_data", i), 32'(out_data), 32'h0025);
      check($sformatf("stall%0d_addr", i), 32'(out_addr), 32'd6);
      if (i < 2) cycle();
    end
    out_ready = 1'b1;
    cycle();
    check("stall_next_data", 32'(out_data), 32'h0000);
    check("stall_next_addr", 32'(out_addr), 32'd7);
    check("stall_next_last", 32'(out_last), 32'd1);
    cycle();
    cycle();

    // Empty burst and clamped burst.
    run_burst(4'd5, 5'd0, span);
    check("empty_span", 32'(span), 32'd2);
    check("empty_beats", 32'(log_q.size()), 32'd0);
    run_burst(4'd3, 5'd20, span);
    check("clamp_beats", 32'(log_q.size()), 32'd16);
    check("clamp_span", 32'(span), 32'd18);

    // Reset during the second beat of an 8-beat burst.
    base_addr = 4'd0; count = 5'd8; start = 1'b1; out_ready = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    check("mid_addr_before_rst", 32'(out_addr), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_zero_outputs("midrst");
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) cycle();

    // Start ignored during SEND; register overwrite after a beat is presented.
    log_q.delete();
    base_addr = 4'd8; count = 5'd4; start = 1'b1; out_ready = 1'b1;
    cycle();
    base_addr = 4'd2; count = 5'd1;
    cycle();
    check("ow_addr", 32'(out_addr), 32'd9);
    out_ready = 1'b0;
    rf[9] = 16'hBEEF;
    cycle();
    check("ow_hold_data", 32'(out_data), 32'h0404);
    start = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) cycle();
    check("ow_beats", 32'(log_q.size()), 32'd4);
    check_beat(0, 4'd8,  16'h5A5A, 1'b0);
    check_beat(1, 4'd9,  16'h0404, 1'b0);
    check_beat(3, 4'd11, 16'h2468, 1'b1);
    load_defaults();

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      start     = ($urandom % 4) == 0;
      base_addr = 4'($urandom);
      count     = ($urandom % 2 == 0) ? 5'($urandom % 6) : 5'($urandom);
      out_ready = ($urandom % 4) != 0;
      if ($urandom % 8 == 0) rf[$urandom % 16] = 16'($urandom);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
